// File: rtl/beat_tick_gen.sv
// Beat/tick generator: NUM_CH independent programmable dividers that produce
// a one-cycle tick, a half-rate square wave, a beat index within a bar and a
// bar pulse. Divisors are staged in a shadow register and only take effect at
// a period boundary, so a running period is never cut short or stretched.
module beat_tick_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 6250000,
    parameter int BEATS   = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [NUM_CH-1:0]                   ch_en,
    input  logic                                sync_clr,
    input  logic                                div_ld,
    input  logic [2:0]                          div_sel,
    input  logic [CNT_W-1:0]                    div_val,
    output logic                                ld_err,
    output logic [NUM_CH-1:0]                   tick_out,
    output logic [NUM_CH-1:0]                   sq_out,
    output logic [NUM_CH-1:0]                   bar_out,
    output logic [NUM_CH*$clog2(BEATS)-1:0]     beat_idx
);

    localparam int               BW        = $clog2(BEATS);
    localparam logic [CNT_W-1:0] DEF_VAL   = CNT_W'(DEF_DIV);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);

    logic [CNT_W-1:0] shd_q  [NUM_CH];
    logic [CNT_W-1:0] act_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [BW-1:0]    beat_q [NUM_CH];

    logic              ld_ok;
    logic [NUM_CH-1:0] ld_hit;

    // Decode the shared load port: a load is legal only for a non-zero divisor
    // aimed at an existing channel; ld_hit selects the channel it writes.
    always_comb begin
        ld_ok  = div_ld && (div_val != '0) && (int'(div_sel) < NUM_CH);
        ld_hit = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ld_hit[n] = ld_ok && (int'(div_sel) == n);
        end
    end

    // Flag a rejected load one cycle later; nothing else changes on rejection.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ld_err <= 1'b0;
        end else begin
            ld_err <= div_ld && !ld_ok;
        end
    end

    // Per-channel divider: disable holds the channel cleared and keeps act
    // tracking shd, sync_clr restarts the phase without a tick, otherwise the
    // counter runs and the wrap edge ticks, advances the beat and adopts shd.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int n = 0; n < NUM_CH; n++) begin
                shd_q[n]    <= DEF_VAL;
                act_q[n]    <= DEF_VAL;
                cnt_q[n]    <= '0;
                beat_q[n]   <= '0;
                tick_out[n] <= 1'b0;
                sq_out[n]   <= 1'b0;
                bar_out[n]  <= 1'b0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ld_hit[n]) begin
                    shd_q[n] <= div_val;
                end
                if (!ch_en[n]) begin
                    act_q[n]    <= shd_q[n];
                    cnt_q[n]    <= '0;
                    beat_q[n]   <= '0;
                    tick_out[n] <= 1'b0;
                    sq_out[n]   <= 1'b0;
                    bar_out[n]  <= 1'b0;
                end else if (sync_clr) begin
                    cnt_q[n]    <= '0;
                    beat_q[n]   <= '0;
                    tick_out[n] <= 1'b0;
                    sq_out[n]   <= 1'b0;
                    bar_out[n]  <= 1'b0;
                end else if (cnt_q[n] == (act_q[n] - CNT_W'(1))) begin
                    act_q[n]    <= shd_q[n];
                    cnt_q[n]    <= '0;
                    tick_out[n] <= 1'b1;
                    sq_out[n]   <= ~sq_out[n];
                    if (beat_q[n] == LAST_BEAT) begin
                        beat_q[n]  <= '0;
                        bar_out[n] <= 1'b1;
                    end else begin
                        beat_q[n]  <= beat_q[n] + BW'(1);
                        bar_out[n] <= 1'b0;
                    end
                end else begin
                    cnt_q[n]    <= cnt_q[n] + CNT_W'(1);
                    tick_out[n] <= 1'b0;
                    bar_out[n]  <= 1'b0;
                end
            end
        end
    end

    // Pack the registered beat indices onto the flat output bus.
    always_comb begin
        beat_idx = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            beat_idx[n*BW +: BW] = beat_q[n];
        end
    end

endmodule
